tc_count_sched: RTL and testbench

- Round-robin scheduler that shares one CW-bit terminal-count counter among NREQ requesters.
- Each granted requester receives one full count sweep, 0 to MAX (MAX = 2^CW-1), and then a done pulse.
- Output t is high exactly when count equals MAX, so downstream terminal-count logic can be checked with the invariants "count<MAX implies ~t" and "count==MAX implies t".
- Sits between requesting blocks and the shared counter/terminal-detect datapath.

---
 rtl/tc_count_sched.sv | 88 ++++++++
 tb/tb_tc_count_sched.sv | 136 +++++++++++++
 2 files changed

// File: rtl/tc_count_sched.sv
// tc_count_sched: round-robin scheduler sharing one CW-bit terminal-count counter among NREQ requesters.
// Define TC_SCHED_ASSERT_EN to compile in the embedded concurrent assertions.
module tc_count_sched #(
    parameter int NREQ = 4,
    parameter int CW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            hold,
    output logic [NREQ-1:0] gnt,
    output logic [CW-1:0]   count,
    output logic            t,
    output logic [NREQ-1:0] done,
    output logic            busy
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] MAX = '1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [PW-1:0] ptr, win, sel, idx, nxt;
    // Scan downward in priority so the first set bit at or after ptr wins last.
    always_comb begin
        sel = ptr;
        idx = ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (req[idx]) sel = idx;
        end
    end
    assign nxt  = PW'((int'(win) + 1) % NREQ);
    assign t    = (state == RUN) && (count == MAX);
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            count <= '0;
            done  <= '0;
            ptr   <= '0;
            win   <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    state <= RUN;
                    win   <= sel;
                    gnt   <= NREQ'(1) << sel;
                    count <= '0;
                end
                RUN: if (!req[win]) begin
                    state <= IDLE;
                    gnt   <= '0;
                    count <= '0;
                    ptr   <= nxt;
                end else if (!hold) begin
                    if (count == MAX) begin
                        state <= DONE;
                        gnt   <= '0;
                        count <= '0;
                        done  <= NREQ'(1) << win;
                        ptr   <= nxt;
                    end else count <= count + CW'(1);
                end
                DONE: begin
                    done  <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef TC_SCHED_ASSERT_EN
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
        else $error("a_gnt_onehot0");
    a_done_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(done))
        else $error("a_done_onehot0");
    a_below_max_no_t: assert property (@(posedge clk) disable iff (rst) (count != MAX) |-> !t)
        else $error("a_below_max_no_t");
    a_max_in_run_t: assert property (@(posedge clk) disable iff (rst) (state == RUN && count == MAX) |-> t)
        else $error("a_max_in_run_t");
    for (genvar g = 0; g < NREQ; g++) begin : g_a
        a_done_after_t: assert property (@(posedge clk) disable iff (rst) done[g] |-> $past(gnt[g] && t))
            else $error("a_done_after_t");
        a_drop_no_done: assert property (@(posedge clk) disable iff (rst) (state == RUN && !req[g]) |=> !done[g])
            else $error("a_drop_no_done");
    end
`endif
endmodule

// File: tb/tb_tc_count_sched.sv
// tb_tc_count_sched: directed checks of grant order, sweep timing, hold, drop and reset abort.
module tb_tc_count_sched;
    logic       clk = 0, rst = 1, hold = 0, t, busy;
    logic [3:0] req = 0, gnt, done, count;
    int checks = 0, errors = 0;
    tc_count_sched #(.NREQ(4), .CW(4)) dut (
        .clk(clk), .rst(rst), .req(req), .hold(hold), .gnt(gnt),
        .count(count), .t(t), .done(done), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    initial begin
        tick(2);
        rst = 0;
        chk("rst_gnt", gnt, 0);
        chk("rst_count", count, 0);
        chk("rst_t", t, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        // Single requester: full sweep, done at cycle 17, idle at 18
        req = 4'b0001;
        tick(1);
        chk("s1_gnt", gnt, 4'b0001);
        chk("s1_count0", count, 0);
        chk("s1_busy", busy, 1);
        tick(14);
        chk("s1_count14", count, 14);
        chk("s1_t_low", t, 0);
        tick(1);
        chk("s1_count15", count, 15);
        chk("s1_t_high", t, 1);
        tick(1);
        chk("s1_done", done, 4'b0001);
        chk("s1_done_gnt", gnt, 0);
        chk("s1_done_count", count, 0);
        chk("s1_done_t", t, 0);
        chk("s1_done_busy", busy, 1);
        req = 0;
        tick(1);
        chk("s1_idle_busy", busy, 0);
        chk("s1_idle_done", done, 0);
        // All requesting: round-robin 0,1,2,3,0 with 18-cycle done spacing
        rst = 1;
        tick(1);
        rst = 0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("rr_gnt", gnt, 4'b0001 << (k % 4));
            tick(16);
            chk("rr_done", done, 4'b0001 << (k % 4));
            chk("rr_gnt_off", gnt, 0);
            tick(1);
            chk("rr_idle_busy", busy, 0);
        end
        req = 0;
        rst = 1;
        tick(1);
        rst = 0;
        // Hold for five edges at count 4 delays done to cycle 22
        req = 4'b0001;
        tick(5);
        chk("h_count4", count, 4);
        hold = 1;
        tick(5);
        chk("h_frozen", count, 4);
        chk("h_frozen_t", t, 0);
        hold = 0;
        tick(11);
        chk("h_count15", count, 15);
        chk("h_t", t, 1);
        chk("h_nodone", done, 0);
        tick(1);
        chk("h_done22", done, 4'b0001);
        req = 0;
        tick(1);
        rst = 1;
        tick(1);
        rst = 0;
        // Drop of req[2] at count 7 aborts with no done; req[3] served next
        req = 4'b1100;
        tick(1);
        chk("d_gnt2", gnt, 4'b0100);
        tick(7);
        chk("d_count7", count, 7);
        req = 4'b1000;
        tick(1);
        chk("d_gnt_off", gnt, 0);
        chk("d_count0", count, 0);
        chk("d_nodone", done, 0);
        chk("d_busy", busy, 0);
        tick(1);
        chk("d_gnt3", gnt, 4'b1000);
        tick(10);
        chk("d_count10", count, 10);
        // Reset mid-sweep: silent abort and pointer back to 0
        rst = 1;
        tick(1);
        chk("r_gnt", gnt, 0);
        chk("r_count", count, 0);
        chk("r_t", t, 0);
        chk("r_done", done, 0);
        chk("r_busy", busy, 0);
        rst = 0;
        req = 4'b1010;
        tick(1);
        chk("r_gnt1", gnt, 4'b0010);
        tick(15);
        chk("r_count15", count, 15);
        // Hold at terminal count keeps t high
        hold = 1;
        tick(2);
        chk("m_count", count, 15);
        chk("m_t", t, 1);
        chk("m_nodone", done, 0);
        hold = 0;
        tick(1);
        chk("m_done", done, 4'b0010);
        chk("m_t_off", t, 0);
        req = 0;
        tick(1);
        chk("m_idle", busy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
